// File: rtl/aq_reduce.sv
// aq_reduce: streaming ARGB8888 nearest-neighbour down-scaler.
// One accumulator per axis walks the source raster; a pixel is kept when both
// the row accumulator (updated at line start) and the column accumulator
// (updated per pixel) wrap past the source size. One clock of latency and no
// backpressure.
module aq_reduce (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [10:0] ORG_X,
  input  logic [10:0] ORG_Y,
  input  logic [10:0] CNV_X,
  input  logic [10:0] CNV_Y,
  input  logic        DIN_WE,
  input  logic        DIN_START_X,
  input  logic        DIN_START_Y,
  input  logic [7:0]  DIN_A,
  input  logic [7:0]  DIN_R,
  input  logic [7:0]  DIN_G,
  input  logic [7:0]  DIN_B,
  output logic        DOUT_OE,
  output logic        DOUT_START_X,
  output logic        DOUT_START_Y,
  output logic [7:0]  DOUT_A,
  output logic [7:0]  DOUT_R,
  output logic [7:0]  DOUT_G,
  output logic [7:0]  DOUT_B
);

  // Frame/line events and whether this input is processed at all.
  logic line_start, frame_start, active;
  assign line_start  = DIN_WE & DIN_START_X;
  assign frame_start = line_start & DIN_START_Y;

  // Architectural state.
  logic        armed_q, armed_d;
  logic [10:0] org_x_q, org_x_d, org_y_q, org_y_d;
  logic [10:0] cnv_x_q, cnv_x_d, cnv_y_q, cnv_y_d;
  logic [11:0] xacc_q, xacc_d, yacc_q, yacc_d;
  logic        row_sel_q, row_sel_d;
  logic        pend_x_q, pend_x_d, pend_y_q, pend_y_d;

  assign active = DIN_WE & (armed_q | frame_start);

  // The frame-start pixel sees the live configuration; later pixels the shadow.
  logic [10:0] cur_org_x, cur_org_y, cur_cnv_x, cur_cnv_y, eff_x, eff_y;
  assign cur_org_x = frame_start ? ORG_X : org_x_q;
  assign cur_org_y = frame_start ? ORG_Y : org_y_q;
  assign cur_cnv_x = frame_start ? CNV_X : cnv_x_q;
  assign cur_cnv_y = frame_start ? CNV_Y : cnv_y_q;
  // Upscaling is not supported: an oversized target clamps to pass-through.
  assign eff_x = (cur_cnv_x < cur_org_x) ? cur_cnv_x : cur_org_x;
  assign eff_y = (cur_cnv_y < cur_org_y) ? cur_cnv_y : cur_org_y;

  // Candidate accumulator sums. A zero effective size (CNV or ORG zero) never
  // selects, so an empty configuration emits nothing.
  logic [11:0] y_next, x_next;
  logic        row_hit, col_hit;
  assign y_next  = (frame_start ? 12'd0 : yacc_q) + {1'b0, eff_y};
  assign x_next  = (line_start  ? 12'd0 : xacc_q) + {1'b0, eff_x};
  assign row_hit = (eff_y != 11'd0) && (y_next >= {1'b0, cur_org_y});
  assign col_hit = (eff_x != 11'd0) && (x_next >= {1'b0, cur_org_x});

  logic emit, emit_sx, emit_sy;

  // Next-state: configuration capture, accumulator stepping and start flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    armed_d   = armed_q;
    org_x_d   = org_x_q;
    org_y_d   = org_y_q;
    cnv_x_d   = cnv_x_q;
    cnv_y_d   = cnv_y_q;
    xacc_d    = xacc_q;
    yacc_d    = yacc_q;
    row_sel_d = row_sel_q;
    pend_x_d  = pend_x_q;
    pend_y_d  = pend_y_q;
    emit      = 1'b0;
    emit_sx   = 1'b0;
    emit_sy   = 1'b0;

    if (frame_start) begin
      armed_d  = 1'b1;
      org_x_d  = ORG_X;
      org_y_d  = ORG_Y;
      cnv_x_d  = CNV_X;
      cnv_y_d  = CNV_Y;
      pend_y_d = 1'b1;
    end

    if (active) begin
      if (line_start) begin
        row_sel_d = row_hit;
        yacc_d    = row_hit ? (y_next - {1'b0, cur_org_y}) : y_next;
        pend_x_d  = 1'b1;
      end
      xacc_d = col_hit ? (x_next - {1'b0, cur_org_x}) : x_next;
      emit   = row_sel_d & col_hit;
    end

    // The start markers ride on the first emitted pixel, which may be the
    // line/frame start pixel itself.
    if (emit) begin
      emit_sx  = pend_x_d;
      emit_sy  = pend_y_d;
      pend_x_d = 1'b0;
      pend_y_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed_q   <= 1'b0;
      org_x_q   <= '0;
      org_y_q   <= '0;
      cnv_x_q   <= '0;
      cnv_y_q   <= '0;
      xacc_q    <= '0;
      yacc_q    <= '0;
      row_sel_q <= 1'b0;
      pend_x_q  <= 1'b0;
      pend_y_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      armed_q   <= armed_d;
      org_x_q   <= org_x_d;
      org_y_q   <= org_y_d;
      cnv_x_q   <= cnv_x_d;
      cnv_y_q   <= cnv_y_d;
      xacc_q    <= xacc_d;
      yacc_q    <= yacc_d;
      row_sel_q <= row_sel_d;
      pend_x_q  <= pend_x_d;
      pend_y_q  <= pend_y_d;
    end
  end

  // Output stage: strobes pulse per emitted pixel, pixel data holds otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOUT_OE      <= 1'b0;
      DOUT_START_X <= 1'b0;
      DOUT_START_Y <= 1'b0;
      DOUT_A       <= '0;
      DOUT_R       <= '0;
      DOUT_G       <= '0;
      DOUT_B       <= '0;
    end else begin
      DOUT_OE      <= emit;
      DOUT_START_X <= emit_sx;
      DOUT_START_Y <= emit_sy;
      if (emit) begin
        DOUT_A <= DIN_A;
        DOUT_R <= DIN_R;
        DOUT_G <= DIN_G;
        DOUT_B <= DIN_B;
      end
    end
  end

endmodule

// File: tb/tb_aq_reduce.sv
// tb_aq_reduce: drives frames into aq_reduce and compares every output cycle
// against a frame-level model that picks rows/columns with the closed-form
// nearest-neighbour rule floor((i+1)*e/n) != floor(i*e/n).
module tb_aq_reduce;

  logic        CLK, RST_N;
  logic [10:0] ORG_X, ORG_Y, CNV_X, CNV_Y;
  logic        DIN_WE, DIN_START_X, DIN_START_Y;
  logic [7:0]  DIN_A, DIN_R, DIN_G, DIN_B;
  logic        DOUT_OE, DOUT_START_X, DOUT_START_Y;
  logic [7:0]  DOUT_A, DOUT_R, DOUT_G, DOUT_B;

  aq_reduce dut (
    .CLK(CLK), .RST_N(RST_N),
    .ORG_X(ORG_X), .ORG_Y(ORG_Y), .CNV_X(CNV_X), .CNV_Y(CNV_Y),
    .DIN_WE(DIN_WE), .DIN_START_X(DIN_START_X), .DIN_START_Y(DIN_START_Y),
    .DIN_A(DIN_A), .DIN_R(DIN_R), .DIN_G(DIN_G), .DIN_B(DIN_B),
    .DOUT_OE(DOUT_OE), .DOUT_START_X(DOUT_START_X), .DOUT_START_Y(DOUT_START_Y),
    .DOUT_A(DOUT_A), .DOUT_R(DOUT_R), .DOUT_G(DOUT_G), .DOUT_B(DOUT_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [34:0] dout_vec;
  assign dout_vec = {DOUT_OE, DOUT_START_X, DOUT_START_Y, DOUT_A, DOUT_R, DOUT_G, DOUT_B};

  typedef struct { logic we; logic sx; logic sy; logic [31:0] px; } stim_t;

  // Test-plan pixel rows: even source rows and odd source rows.
  logic [31:0] row_even [4] = '{32'hF0E0D0C0, 32'hE0D0C0B0, 32'hD0C0B0A0, 32'hC0B0A090};
  logic [31:0] row_odd  [4] = '{32'hB0A09080, 32'hA0908070, 32'h90807060, 32'h80706050};

  // Emitted pixels seen by the last run_frame: {start_x, start_y, argb}.
  logic [33:0] obs_q[$];

  // ---------------- reference model ----------------
  bit          m_armed, m_row_sel, m_pend_x, m_pend_y;
  int          m_ox, m_oy, m_ex, m_ey, m_row, m_col;
  logic [31:0] m_last;
  logic [34:0] exp_vec;

  function automatic bit picks(int idx, int e, int n);
    if (e == 0 || n == 0) return 1'b0;
    return ((idx + 1) * e) / n != (idx * e) / n;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_row_sel = 0; m_pend_x = 0; m_pend_y = 0;
    m_ox = 0; m_oy = 0; m_ex = 0; m_ey = 0; m_row = 0; m_col = 0;
    m_last = '0; exp_vec = '0;
  endtask

  task automatic model_apply(input stim_t s);
    bit emit;
    emit = 1'b0;
    if (s.we) begin
      if (s.sx && s.sy) begin
        m_armed  = 1;
        m_ox     = int'(ORG_X);
        m_oy     = int'(ORG_Y);
        m_ex     = (CNV_X < ORG_X) ? int'(CNV_X) : int'(ORG_X);
        m_ey     = (CNV_Y < ORG_Y) ? int'(CNV_Y) : int'(ORG_Y);
        m_row    = 0;
        m_pend_y = 1;
      end else if (s.sx && m_armed) begin
        m_row++;
      end
      if (m_armed) begin
        if (s.sx) begin
          m_col     = 0;
          m_pend_x  = 1;
          m_row_sel = picks(m_row, m_ey, m_oy);
        end else begin
          m_col++;
        end
        emit = m_row_sel && picks(m_col, m_ex, m_ox);
      end
    end
    if (emit) begin
      exp_vec  = {1'b1, m_pend_x, m_pend_y, s.px};
      m_pend_x = 0;
      m_pend_y = 0;
      m_last   = s.px;
    end else begin
      exp_vec = {3'b000, m_last};
    end
  endtask

  // Drive one input cycle (away from the edge), advance the model, and return
  // 1 time unit after the sampling edge.
  task automatic step(input stim_t s);
    DIN_WE = s.we; DIN_START_X = s.sx; DIN_START_Y = s.sy;
    {DIN_A, DIN_R, DIN_G, DIN_B} = s.px;
    model_apply(s);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cfg(input int ox, oy, cx, cy);
    ORG_X = 11'(ox); ORG_Y = 11'(oy); CNV_X = 11'(cx); CNV_Y = 11'(cy);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  // Stream h lines of w pixels; compare every cycle including gaps and tail.
  task automatic run_frame(input int w, input int h, input int gap_pct,
                           input bit use_tbl, input bit jitter, input bit sy_line,
                           input bit no_fs, input bit scramble, input string tag);
    stim_t sq[$];
    stim_t s;
    int    len;
    obs_q.delete();
    for (int r = 0; r < h; r++) begin
      len = jitter ? w + int'($urandom_range(0, 3)) - 1 : w;
      if (len < 1) len = 1;
      for (int c = 0; c < len; c++) begin
        for (int g = 0; g < 3 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
          s.we = 1'b0; s.sx = 1'($urandom); s.sy = 1'($urandom); s.px = $urandom;
          sq.push_back(s);
        end
        s.we = 1'b1;
        s.sx = (c == 0);
        s.sy = !no_fs && (r == 0) && (c == 0 || sy_line);
        s.px = (use_tbl && c < 4) ? ((r % 2 == 0) ? row_even[c] : row_odd[c]) : $urandom;
        sq.push_back(s);
      end
    end
    for (int k = 0; k < 2; k++) begin
      s.we = 1'b0; s.sx = 1'b0; s.sy = 1'b0; s.px = $urandom;
      sq.push_back(s);
    end
    foreach (sq[i]) begin
      step(sq[i]);
      if (scramble && i == 0) set_cfg($urandom_range(0, 20), $urandom_range(0, 20),
                                      $urandom_range(0, 20), $urandom_range(0, 20));
      n_cmp++;
      if (dout_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, i, dout_vec, exp_vec);
      end
      if (DOUT_OE === 1'b1) obs_q.push_back({DOUT_START_X, DOUT_START_Y, DOUT_A, DOUT_R, DOUT_G, DOUT_B});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    model_reset();
    set_cfg(0, 0, 0, 0);
    DIN_WE = 0; DIN_START_X = 0; DIN_START_Y = 0; {DIN_A, DIN_R, DIN_G, DIN_B} = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if (dout_vec !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", dout_vec);
    end
    RST_N = 1'b1;
  endtask

  logic [33:0] dir_q[$];

  task automatic test_decimate();
    set_cfg(4, 4, 3, 3);
    run_frame(4, 4, 0, 1, 0, 0, 0, 0, "decimate");
    dir_q = obs_q;
    n_cmp++;
    if (obs_q.size() != 9) begin
      n_fail++; $display("FAIL decimate_count: got %0d expected 9", obs_q.size());
    end
    n_cmp++;
    if (obs_q[0] !== {2'b11, 32'hA0908070}) begin
      n_fail++; $display("FAIL decimate_first: got %h expected %h", obs_q[0], {2'b11, 32'hA0908070});
    end
    n_cmp++;
    if (obs_q[3] !== {2'b10, 32'hE0D0C0B0} || obs_q[4] !== {2'b00, 32'hD0C0B0A0} ||
        obs_q[5] !== {2'b00, 32'hC0B0A090}) begin
      n_fail++;
      $display("FAIL decimate_row2: got %h %h %h expected %h %h %h", obs_q[3], obs_q[4], obs_q[5],
               {2'b10, 32'hE0D0C0B0}, {2'b00, 32'hD0C0B0A0}, {2'b00, 32'hC0B0A090});
    end
  endtask

  task automatic test_passthrough();
    set_cfg(4, 4, 4, 4);
    run_frame(4, 4, 0, 1, 0, 0, 0, 0, "passthrough");
    n_cmp++;
    if (obs_q.size() != 16 || obs_q[0] !== {2'b11, 32'hF0E0D0C0} || obs_q[4] !== {2'b10, 32'hB0A09080}) begin
      n_fail++;
      $display("FAIL passthrough: got n=%0d first=%h line1=%h expected n=16 %h %h", obs_q.size(),
               obs_q[0], obs_q[4], {2'b11, 32'hF0E0D0C0}, {2'b10, 32'hB0A09080});
    end
  endtask

  task automatic test_clamp();
    set_cfg(4, 4, 8, 4);
    run_frame(4, 4, 0, 1, 0, 1, 0, 0, "clamp");
    n_cmp++;
    if (obs_q.size() != 16) begin
      n_fail++; $display("FAIL clamp_count: got %0d expected 16", obs_q.size());
    end
  endtask

  task automatic test_zero();
    set_cfg(4, 4, 0, 0);
    run_frame(4, 4, 0, 0, 0, 0, 0, 0, "cnv_zero");
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL cnv_zero_count: got %0d expected 0", obs_q.size());
    end
    set_cfg(0, 4, 3, 3);
    run_frame(4, 4, 0, 0, 0, 0, 0, 0, "org_zero");
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL org_zero_count: got %0d expected 0", obs_q.size());
    end
  endtask

  task automatic test_unarmed();
    do_reset();
    set_cfg(4, 4, 4, 4);
    run_frame(4, 3, 10, 0, 0, 0, 1, 0, "unarmed");
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL unarmed_count: got %0d expected 0", obs_q.size());
    end
    set_cfg(4, 4, 3, 3);
    run_frame(4, 4, 0, 1, 0, 0, 0, 0, "after_arm");
    n_cmp++;
    if (obs_q.size() != 9) begin
      n_fail++; $display("FAIL after_arm_count: got %0d expected 9", obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    set_cfg(4, 4, 4, 4);
    for (int c = 0; c < 6; c++) begin
      s.we = 1'b1; s.sx = (c % 4 == 0); s.sy = (c == 0); s.px = 32'hFFFF0000 | 32'(c + 1);
      step(s);
      n_cmp++;
      if (dout_vec !== exp_vec) begin
        n_fail++; $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", c, dout_vec, exp_vec);
      end
    end
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dout_vec !== 35'd0) begin
      n_fail++; $display("FAIL reset_mid_async: got %h expected 0", dout_vec);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    run_frame(4, 2, 0, 0, 0, 0, 1, 0, "reset_mid_nofs");
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_nofs_count: got %0d expected 0", obs_q.size());
    end
    run_frame(4, 4, 0, 1, 0, 0, 0, 0, "reset_mid_resume");
    n_cmp++;
    if (obs_q.size() != 16) begin
      n_fail++; $display("FAIL reset_mid_resume_count: got %0d expected 16", obs_q.size());
    end
  endtask

  task automatic test_gaps();
    set_cfg(4, 4, 3, 3);
    run_frame(4, 4, 50, 1, 0, 0, 0, 0, "gaps");
    n_cmp++;
    if (obs_q.size() != dir_q.size()) begin
      n_fail++; $display("FAIL gaps_count: got %0d expected %0d", obs_q.size(), dir_q.size());
    end else begin
      foreach (dir_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== dir_q[i]) begin
          n_fail++; $display("FAIL gaps_seq[%0d]: got %h expected %h", i, obs_q[i], dir_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int ox, oy;
    for (int f = 0; f < 12; f++) begin
      ox = $urandom_range(1, 9);
      oy = $urandom_range(1, 9);
      set_cfg(ox, oy, $urandom_range(0, 11), $urandom_range(0, 11));
      run_frame(ox, oy + int'($urandom_range(0, 1)), 30, 0, 1'($urandom), 1'($urandom),
                0, 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_decimate();
    test_passthrough();
    test_clamp();
    test_zero();
    test_unarmed();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
